// File: rtl/usbdev_linestate_mon.sv
// USB line-state monitor: glitch-filters D+/D-, debounces VBUS sense and
// tracks the link state (disconnected/active/reset/suspend) with event pulses.
module usbdev_linestate_mon #(
  parameter int FilterCycles = 3,
  parameter int ResetUs      = 3,
  parameter int SuspendUs    = 3000,
  parameter int SenseUs      = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       us_tick_i,
  input  logic       rx_dp_i,
  input  logic       rx_dn_i,
  input  logic       pwr_sense_i,
  output logic [1:0] line_state_o,
  output logic       sense_o,
  output logic [1:0] link_state_o,
  output logic       bus_reset_evt_o,
  output logic       suspend_evt_o,
  output logic       resume_evt_o,
  output logic       vbus_lost_evt_o
);

  localparam int FiltW  = $clog2(FilterCycles + 1);
  localparam int TimerW = $clog2(SuspendUs + 1);
  localparam int SenseW = $clog2(SenseUs + 1);

  localparam logic [FiltW-1:0]  FILT_LAST  = FiltW'(FilterCycles - 1);
  localparam logic [TimerW-1:0] TIMER_MAX  = '1;
  localparam logic [TimerW-1:0] RESET_T    = TimerW'(ResetUs);
  localparam logic [TimerW-1:0] SUSPEND_T  = TimerW'(SuspendUs);
  localparam logic [SenseW-1:0] SENSE_LAST = SenseW'(SenseUs - 1);

  localparam logic [1:0] LINE_SE0 = 2'd0;
  localparam logic [1:0] LINE_J   = 2'd1;
  localparam logic [1:0] LINE_K   = 2'd2;

  typedef enum logic [1:0] {
    LINK_DISCONNECTED = 2'd0,
    LINK_ACTIVE       = 2'd1,
    LINK_RESET        = 2'd2,
    LINK_SUSPEND      = 2'd3
  } link_e;

  logic [1:0]        raw;
  logic [1:0]        raw_prev_reg;
  logic [FiltW-1:0]  filt_cnt_reg, filt_cnt_next;
  logic [1:0]        line_state_reg, line_state_next;
  logic [TimerW-1:0] timer_reg, timer_next;
  logic [SenseW-1:0] sense_cnt_reg, sense_cnt_next;
  logic              sense_reg, sense_next;
  link_e             link_state_reg;
  logic              bus_reset_evt_reg, suspend_evt_reg, resume_evt_reg, vbus_lost_evt_reg;

  assign raw = {rx_dn_i, rx_dp_i};

  // Accept the raw state on the cycle its run length reaches FilterCycles.
  always_comb begin
    filt_cnt_next   = filt_cnt_reg;
    line_state_next = line_state_reg;
    if (raw != raw_prev_reg) begin
      filt_cnt_next = '0;
    end else if (filt_cnt_reg != FILT_LAST) begin
      filt_cnt_next = filt_cnt_reg + 1'b1;
    end
    if (filt_cnt_next == FILT_LAST) begin
      line_state_next = raw;
    end
  end

  // Duration of the current filtered state; a state change outranks a tick.
  always_comb begin
    timer_next = timer_reg;
    if (line_state_next != line_state_reg) begin
      timer_next = '0;
    end else if (us_tick_i && (timer_reg != TIMER_MAX)) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  always_comb begin
    sense_cnt_next = sense_cnt_reg;
    sense_next     = sense_reg;
    if (pwr_sense_i == sense_reg) begin
      sense_cnt_next = '0;
    end else if (us_tick_i) begin
      if (sense_cnt_reg >= SENSE_LAST) begin
        sense_next     = pwr_sense_i;
        sense_cnt_next = '0;
      end else begin
        sense_cnt_next = sense_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_prev_reg   <= LINE_SE0;
      filt_cnt_reg   <= '0;
      line_state_reg <= LINE_SE0;
      timer_reg      <= '0;
      sense_cnt_reg  <= '0;
      sense_reg      <= 1'b0;
    end else begin
      raw_prev_reg   <= raw;
      filt_cnt_reg   <= filt_cnt_next;
      line_state_reg <= line_state_next;
      timer_reg      <= timer_next;
      sense_cnt_reg  <= sense_cnt_next;
      sense_reg      <= sense_next;
    end
  end

  // Loss of VBUS overrides any other transition and its event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_state_reg    <= LINK_DISCONNECTED;
      bus_reset_evt_reg <= 1'b0;
      suspend_evt_reg   <= 1'b0;
      resume_evt_reg    <= 1'b0;
      vbus_lost_evt_reg <= 1'b0;
    end else begin
      bus_reset_evt_reg <= 1'b0;
      suspend_evt_reg   <= 1'b0;
      resume_evt_reg    <= 1'b0;
      vbus_lost_evt_reg <= 1'b0;
      if ((link_state_reg != LINK_DISCONNECTED) && !sense_reg) begin
        link_state_reg    <= LINK_DISCONNECTED;
        vbus_lost_evt_reg <= 1'b1;
      end else begin
        case (link_state_reg)
          LINK_DISCONNECTED: begin
            if (sense_reg) link_state_reg <= LINK_ACTIVE;
          end
          LINK_ACTIVE: begin
            if ((line_state_reg == LINE_SE0) && (timer_reg >= RESET_T)) begin
              link_state_reg    <= LINK_RESET;
              bus_reset_evt_reg <= 1'b1;
            end else if ((line_state_reg == LINE_J) && (timer_reg >= SUSPEND_T)) begin
              link_state_reg  <= LINK_SUSPEND;
              suspend_evt_reg <= 1'b1;
            end
          end
          LINK_RESET: begin
            if (line_state_reg != LINE_SE0) link_state_reg <= LINK_ACTIVE;
          end
          LINK_SUSPEND: begin
            if ((line_state_reg == LINE_K) || (line_state_reg == LINE_SE0)) begin
              link_state_reg <= LINK_ACTIVE;
              resume_evt_reg <= 1'b1;
            end
          end
          default: link_state_reg <= LINK_DISCONNECTED;
        endcase
      end
    end
  end

  assign line_state_o    = line_state_reg;
  assign sense_o         = sense_reg;
  assign link_state_o    = link_state_reg;
  assign bus_reset_evt_o = bus_reset_evt_reg;
  assign suspend_evt_o   = suspend_evt_reg;
  assign resume_evt_o    = resume_evt_reg;
  assign vbus_lost_evt_o = vbus_lost_evt_reg;

endmodule
